// File: rtl/sha256_padder.sv
//============================================================================
// Module   : sha256_padder
// Purpose  : Collects a big-endian 32-bit message stream into 512-bit SHA-256
//            blocks and appends the standard padding: one 0x80 byte, zero
//            fill, and the 64-bit message length in bits. Messages whose pad
//            byte leaves no room for the length get an extra length block.
// Config   : SHA256_PADDER_BYTE_EN - when defined, the final word may carry
//            0..4 valid bytes (in_bytes). When undefined, every word is taken
//            as 4 bytes and in_bytes is ignored.
// Ports    : clk          - sole clock, rising edge
//            reset_n      - asynchronous active-low reset
//            in_valid     - in_data/in_last/in_bytes valid
//            in_ready     - a word is accepted this cycle (FILL only)
//            in_data[31:0]- message word, first byte in [31:24]
//            in_last      - final word of the message
//            in_bytes[2:0]- valid bytes in the final word, left-aligned
//            chunk[511:0] - padded block, word 0 in [511:480]
//            chunk_valid  - block ready for the compressor
//            chunk_ready  - compressor takes the block
//            chunk_first  - first block of a message (load IV)
//            chunk_last   - final block of a message
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module sha256_padder (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_bytes,
    output logic [511:0] chunk,
    output logic         chunk_valid,
    input  logic         chunk_ready,
    output logic         chunk_first,
    output logic         chunk_last
);

    localparam logic [31:0] c_PAD_WORD = 32'h8000_0000;
    localparam logic [3:0]  c_IDX_MAX  = 4'd15;
    localparam logic [3:0]  c_LEN_MAX  = 4'd13;  // last index that leaves room for the length

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_PAD  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_words [16];
    logic [3:0]  r_idx;
    logic [63:0] r_cnt;       // message length in bytes
    logic        r_pend;      // full last word seen; 0x80000000 still to be written
    logic        r_placed;    // pad byte already in the block stream
    logic        r_len_ok;    // pad byte sits at index <= 13 of the current block
    logic        r_first;
    logic        r_last;

    logic        w_accept;
    logic        w_hs;
    logic [2:0]  w_nbytes;
    logic        w_partial;
    logic [31:0] w_fill_word;
    logic [31:0] w_pad_word;
    logic        w_len_ok_nxt;
    logic [63:0] w_bitlen;

    //------------------------------------------------------------------------
    // Byte count of the incoming word
    //------------------------------------------------------------------------
`ifdef SHA256_PADDER_BYTE_EN
    always_comb begin
        w_nbytes = 3'd4;
        if (in_last) begin
            w_nbytes = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
        end
    end
`else
    logic w_unused_bytes;
    assign w_unused_bytes = ^in_bytes;
    assign w_nbytes       = 3'd4;
`endif

    assign w_partial = in_last && (w_nbytes != 3'd4);

    // Partial final word: keep the valid leading bytes, place 0x80 right after
    // them and clear the rest.
    always_comb begin
        w_fill_word = in_data;
        if (w_partial) begin
            case (w_nbytes)
                3'd0:    w_fill_word = c_PAD_WORD;
                3'd1:    w_fill_word = {in_data[31:24], 24'h80_0000};
                3'd2:    w_fill_word = {in_data[31:16], 16'h8000};
                3'd3:    w_fill_word = {in_data[31:8],  8'h80};
                default: w_fill_word = in_data;
            endcase
        end
    end

    assign w_bitlen = r_cnt << 3;

    // Whether the length fits once this PAD word is written: a pending pad
    // byte written now fixes the position, otherwise the earlier decision holds.
    assign w_len_ok_nxt = r_pend ? (r_idx <= c_LEN_MAX) : r_len_ok;

    always_comb begin
        w_pad_word = 32'h0;
        if (r_pend) begin
            w_pad_word = c_PAD_WORD;
        end else if (r_len_ok && (r_idx == 4'd14)) begin
            w_pad_word = w_bitlen[63:32];
        end else if (r_len_ok && (r_idx == c_IDX_MAX)) begin
            w_pad_word = w_bitlen[31:0];
        end
    end

    //------------------------------------------------------------------------
    // FSM: state register
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //------------------------------------------------------------------------
    // FSM: next state and handshake outputs
    //------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        chunk_valid = 1'b0;
        w_accept    = 1'b0;
        w_hs        = 1'b0;
        case (r_state)
            S_FILL: begin
                in_ready = reset_n;
                w_accept = in_valid && reset_n;
                if (w_accept) begin
                    if (r_idx == c_IDX_MAX) begin
                        w_state_nxt = S_OUT;
                    end else if (in_last) begin
                        w_state_nxt = S_PAD;
                    end
                end
            end
            S_PAD: begin
                if (r_idx == c_IDX_MAX) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                chunk_valid = 1'b1;
                w_hs        = chunk_ready;
                if (chunk_ready) begin
                    if (r_last) begin
                        w_state_nxt = S_FILL;
                    end else if (r_pend || r_placed) begin
                        w_state_nxt = S_PAD;
                    end else begin
                        w_state_nxt = S_FILL;
                    end
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    //------------------------------------------------------------------------
    // Datapath
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                r_words[i] <= 32'h0;
            end
            r_idx    <= 4'd0;
            r_cnt    <= 64'd0;
            r_pend   <= 1'b0;
            r_placed <= 1'b0;
            r_len_ok <= 1'b0;
            r_first  <= 1'b1;
            r_last   <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        r_words[r_idx] <= w_fill_word;
                        r_cnt          <= r_cnt + {61'd0, w_nbytes};
                        r_idx          <= r_idx + 4'd1;
                        r_last         <= 1'b0;
                        if (in_last) begin
                            if (w_partial) begin
                                r_placed <= 1'b1;
                                r_len_ok <= (r_idx <= c_LEN_MAX);
                            end else begin
                                r_pend <= 1'b1;
                            end
                        end
                    end
                end
                S_PAD: begin
                    r_words[r_idx] <= w_pad_word;
                    r_idx          <= r_idx + 4'd1;
                    r_len_ok       <= w_len_ok_nxt;
                    if (r_pend) begin
                        r_pend   <= 1'b0;
                        r_placed <= 1'b1;
                    end
                    if (r_idx == c_IDX_MAX) begin
                        r_last <= w_len_ok_nxt;
                    end
                end
                S_OUT: begin
                    if (w_hs) begin
                        r_idx   <= 4'd0;
                        r_first <= r_last;
                        if (r_last) begin
                            r_cnt    <= 64'd0;
                            r_pend   <= 1'b0;
                            r_placed <= 1'b0;
                            r_len_ok <= 1'b0;
                            r_last   <= 1'b0;
                        end else if (r_placed && !r_pend) begin
                            // Extra block: pad byte went out already, length goes at 14/15.
                            r_len_ok <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_idx <= 4'd0;
                end
            endcase
        end
    end

    //------------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_chunk
            assign chunk[511-32*gi -: 32] = r_words[gi];
        end
    endgenerate

    assign chunk_first = r_first;
    assign chunk_last  = r_last;

endmodule

`default_nettype wire

// File: tb/tb_sha256_padder.sv
//============================================================================
// Module   : tb_sha256_padder
// Purpose  : Self-checking bench for sha256_padder. Random messages are
//            padded by a byte-queue model (append 0x80, zero to 56 mod 64,
//            append 64-bit bit length) and compared block by block, with
//            random and forced back-pressure, plus reset scenarios.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sha256_padder;

    localparam int c_CYC_LIMIT = 4000;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic [511:0] chunk;
    logic         chunk_valid;
    logic         chunk_ready;
    logic         chunk_first;
    logic         chunk_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sha256_padder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_bytes    (in_bytes),
        .chunk       (chunk),
        .chunk_valid (chunk_valid),
        .chunk_ready (chunk_ready),
        .chunk_first (chunk_first),
        .chunk_last  (chunk_last)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sends one message of nbytes bytes and checks every padded block.
    // hold5: keep chunk_ready low for the first 5 valid cycles of each block.
    // abc:   use the bytes "abc" instead of random content.
    task automatic run_msg(input int nbytes, input bit hold5, input bit abc);
        logic [7:0]   m [$];
        logic [7:0]   p [$];
        logic [511:0] exp_blk [$];
        logic [511:0] blk;
        logic [63:0]  bitlen;
        int nblk, nw, rem, wi, bi, cyc, stall, id;
        m.delete();
        for (int i = 0; i < nbytes; i++) begin
            if (abc) m.push_back(8'h61 + 8'(i));
            else     m.push_back(8'($urandom));
        end
        p = m;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bitlen = 64'(nbytes) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
            exp_blk.push_back(blk);
        end

        nw  = (nbytes == 0) ? 1 : (nbytes + 3) / 4;
        rem = nbytes - 4 * (nw - 1);
        wi = 0; bi = 0; cyc = 0; stall = 0;
        while (bi < nblk && cyc < c_CYC_LIMIT) begin
            @(negedge clk);
            in_valid = (wi < nw) && ($urandom_range(0, 3) != 0);
            in_last  = (wi == nw - 1);
            for (int k = 0; k < 4; k++) begin
                id = 4 * wi + k;
                in_data[31-8*k -: 8] = (id < nbytes) ? m[id] : 8'($urandom);
            end
`ifdef SHA256_PADDER_BYTE_EN
            if (in_last && rem < 4) in_bytes = 3'(rem);
            else if (in_last)       in_bytes = 3'($urandom_range(4, 7));
            else                    in_bytes = 3'($urandom);
`else
            in_bytes = 3'($urandom);
`endif
            if (hold5 && chunk_valid && stall < 5) begin
                chunk_ready = 1'b0;
                stall++;
            end else begin
                chunk_ready = ($urandom_range(0, 2) != 0);
            end
            #1;
            if (chunk_valid) begin
                check($sformatf("chunk n=%0d blk=%0d", nbytes, bi), chunk, exp_blk[bi]);
                check($sformatf("first n=%0d blk=%0d", nbytes, bi), chunk_first, (bi == 0));
                check($sformatf("last n=%0d blk=%0d", nbytes, bi), chunk_last, (bi == nblk - 1));
                if (chunk_ready) begin
                    bi++;
                    stall = 0;
                end
            end
            if (in_valid && in_ready) wi++;
            cyc++;
        end
        check($sformatf("timeout n=%0d", nbytes), (cyc < c_CYC_LIMIT), 1'b1);
        check($sformatf("words n=%0d", nbytes), wi, nw);
        @(negedge clk);
        in_valid    = 1'b0;
        chunk_ready = 1'b0;
        #1;
        check($sformatf("ready_after n=%0d", nbytes), in_ready, 1'b1);
        check($sformatf("valid_after n=%0d", nbytes), chunk_valid, 1'b0);
    endtask

    // Pulse reset mid-cycle and check the asynchronous reset values.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check({tag, " chunk"},       chunk,       512'd0);
        check({tag, " chunk_valid"}, chunk_valid, 1'b0);
        check({tag, " chunk_first"}, chunk_first, 1'b1);
        check({tag, " chunk_last"},  chunk_last,  1'b0);
        check({tag, " in_ready"},    in_ready,    1'b0);
        @(negedge clk);
        reset_n     = 1'b1;
        in_valid    = 1'b0;
        chunk_ready = 1'b0;
        #1;
        check({tag, " ready_rel"}, in_ready, 1'b1);
    endtask

    // Offer nwords full non-final words and return once they are accepted.
    task automatic push_words(input int nwords);
        int acc, cyc;
        acc = 0; cyc = 0;
        while (acc < nwords && cyc < c_CYC_LIMIT) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_last  = 1'b0;
            in_data  = $urandom;
            in_bytes = 3'($urandom);
            #1;
            if (in_ready) acc++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("push timeout", (cyc < c_CYC_LIMIT), 1'b1);
    endtask

    initial begin
        int n, cyc;
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_data     = 32'h0;
        in_last     = 1'b0;
        in_bytes    = 3'd0;
        chunk_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst chunk",       chunk,       512'd0);
        check("rst chunk_valid", chunk_valid, 1'b0);
        check("rst chunk_first", chunk_first, 1'b1);
        check("rst chunk_last",  chunk_last,  1'b0);
        check("rst in_ready",    in_ready,    1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rel in_ready", in_ready, 1'b1);

        run_msg(32, 1'b0, 1'b0);   // 8 words, single block
        run_msg(80, 1'b0, 1'b0);   // 20 words, two blocks
        run_msg(56, 1'b1, 1'b0);   // 14 words, pad at 14, held chunk
        run_msg(60, 1'b0, 1'b0);   // pad pending at index 15
        run_msg(64, 1'b0, 1'b0);   // exactly one full block of data
        run_msg(52, 1'b0, 1'b0);   // pad at 13, length still fits
        run_msg(4,  1'b0, 1'b0);
`ifdef SHA256_PADDER_BYTE_EN
        run_msg(0,  1'b0, 1'b0);   // empty message
        run_msg(3,  1'b0, 1'b1);   // "abc"
        run_msg(55, 1'b0, 1'b0);
        run_msg(57, 1'b0, 1'b0);
        run_msg(63, 1'b1, 1'b0);   // partial last word at index 15
        run_msg(61, 1'b0, 1'b0);
`endif
        for (int r = 0; r < 10; r++) begin
`ifdef SHA256_PADDER_BYTE_EN
            n = $urandom_range(0, 200);
`else
            n = 4 * $urandom_range(1, 50);
`endif
            run_msg(n, 1'b0, 1'b0);
        end

        // Reset after 5 words of a message; next message starts clean.
        push_words(5);
        do_reset("mid");
        run_msg(32, 1'b0, 1'b0);

        // Reset while a block is waiting in OUT.
        push_words(16);
        cyc = 0;
        while (!chunk_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("out valid", chunk_valid, 1'b1);
        do_reset("out");
        run_msg(80, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
